mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/sat_counter.sv | 26 ++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int STATS_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  typedef enum logic {
    DATA_PRI    = 1'b0,
    FETCH_FORCE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for fetch starvation
// tracking and for the optional grant/conflict statistics.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count < MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-memory arbiter: data wins conflicts until fetch
// starves, then fetch is forced once. Define MEM_ARBITER_STATS_EN for counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_req_ready,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  d_req_valid,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_req_ready,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [STATS_W-1:0]    stat_if_grants,
  output logic [STATS_W-1:0]    stat_d_grants,
  output logic [STATS_W-1:0]    stat_conflicts
`endif
);

  localparam int STARVE_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_t          state;
  arb_state_t          next_state;
  owner_t              rsp_owner;
  logic                rsp_write;
  logic [STARVE_W-1:0] starve_cnt;
  logic                fetch_wins;
  logic                starve_hit;

  // A limit of zero pins fetch priority permanently, independent of the FSM.
  assign fetch_wins = (state == FETCH_FORCE) || (STARVE_LIMIT == 0);

  // Looks at the post-increment count so the forced grant lands on the very
  // next conflict cycle rather than one cycle late.
  assign starve_hit = if_req_valid && !if_req_ready &&
                      ((int'(starve_cnt) + 1) >= STARVE_LIMIT);

  sat_counter #(
    .WIDTH (STARVE_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!if_req_valid || if_req_ready),
    .inc     (if_req_valid && !if_req_ready),
    .count   (starve_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= DATA_PRI;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      DATA_PRI:    if (starve_hit) next_state = FETCH_FORCE;
      FETCH_FORCE: if (if_req_ready || !if_req_valid) next_state = DATA_PRI;
      default:     next_state = DATA_PRI;
    endcase
  end

  // Grants are gated by reset_n so the memory port is quiet while in reset.
  always_comb begin
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (reset_n) begin
      if (if_req_valid && d_req_valid) begin
        if (fetch_wins) if_req_ready = 1'b1;
        else            d_req_ready  = 1'b1;
      end else begin
        if_req_ready = if_req_valid;
        d_req_ready  = d_req_valid;
      end
    end
    if (if_req_ready) begin
      mem_addr = if_addr;
    end else if (d_req_ready) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_owner <= OWN_NONE;
      rsp_write <= 1'b0;
    end else begin
      rsp_owner <= if_req_ready ? OWN_IF : (d_req_ready ? OWN_D : OWN_NONE);
      rsp_write <= d_req_ready && d_we;
    end
  end

  assign if_rsp_valid = (rsp_owner == OWN_IF);
  assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
  assign d_rsp_valid  = (rsp_owner == OWN_D);
  assign d_rsp_data   = (d_rsp_valid && !rsp_write) ? mem_rdata : '0;

`ifdef MEM_ARBITER_STATS_EN
  sat_counter #(
    .WIDTH (STATS_W),
    .LIMIT ((1 << STATS_W) - 1)
  ) u_stat_if (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .inc     (if_req_ready),
    .count   (stat_if_grants)
  );

  sat_counter #(
    .WIDTH (STATS_W),
    .LIMIT ((1 << STATS_W) - 1)
  ) u_stat_d (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .inc     (d_req_ready),
    .count   (stat_d_grants)
  );

  sat_counter #(
    .WIDTH (STATS_W),
    .LIMIT ((1 << STATS_W) - 1)
  ) u_stat_conf (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .inc     (if_req_valid && d_req_valid),
    .count   (stat_conflicts)
  );
`endif

endmodule
